muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/md_iter_datapath.sv | 71 +++++++
 rtl/muldiv_sequencer.sv | 127 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RISC-V M-extension unit.
// The divide datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int XLEN   = 32;
  localparam int ITER_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdOp_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } mdState_e;

  // Two's-complement negation when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] negIf(input logic [XLEN-1:0] value, input logic neg);
    return neg ? (~value + XLEN'(1)) : value;
  endfunction

endpackage

// File: rtl/md_iter_datapath.sv
// One radix-2 step per enabled cycle: shift-add multiply or restoring divide.
// The divide step exists only when MULDIV_DIV_EN is defined.
module md_iter_datapath
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            isDiv,
  input  logic [XLEN-1:0] loadA,
  input  logic [XLEN-1:0] loadB,
  output logic [XLEN-1:0] hiNext,
  output logic [XLEN-1:0] loNext
);

  // hi holds the product accumulator / partial remainder, lo the multiplier / dividend-quotient.
  logic [XLEN:0]   hiReg;
  logic [XLEN:0]   hiStep;
  logic [XLEN:0]   mulSum;
  logic [XLEN-1:0] loReg;
  logic [XLEN-1:0] loStep;
  logic [XLEN-1:0] bReg;

`ifdef MULDIV_DIV_EN
  logic [XLEN:0] divShift;
  logic [XLEN:0] divDiff;
`else
  logic unusedIsDiv;
  assign unusedIsDiv = isDiv;
`endif

  always_comb begin
    mulSum = hiReg + (loReg[0] ? {1'b0, bReg} : '0);
    hiStep = {1'b0, mulSum[XLEN:1]};
    loStep = {mulSum[0], loReg[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    divShift = {hiReg[XLEN-1:0], loReg[XLEN-1]};
    divDiff  = divShift - {1'b0, bReg};
    if (isDiv) begin
      // A clear sign bit means the trial subtraction fits, so keep it.
      if (!divDiff[XLEN]) begin
        hiStep = divDiff;
        loStep = {loReg[XLEN-2:0], 1'b1};
      end else begin
        hiStep = divShift;
        loStep = {loReg[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  assign hiNext = hiStep[XLEN-1:0];
  assign loNext = loStep;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hiReg <= '0;
      loReg <= '0;
      bReg  <= '0;
    end else if (load) begin
      hiReg <= '0;
      loReg <= loadA;
      bReg  <= loadB;
    end else if (step) begin
      hiReg <= hiStep;
      loReg <= loStep;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the iterative M-extension unit: FSM, iteration counter, stall/done and flush.
// Define MULDIV_DIV_EN to build the divide ops; otherwise ops 4-7 complete at once with result 0.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic [2:0]      OpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            DoneMD,
  output logic [XLEN-1:0] ResultMD
);

  localparam logic [1:0] IDLE = MD_IDLE;
  localparam logic [1:0] BUSY = MD_BUSY;
  localparam logic [1:0] DONE = MD_DONE;

  logic [1:0]        stateReg;
  logic [ITER_W-1:0] cntReg;
  logic [2:0]        opReg;
  logic              aNegReg;
  logic              bNegReg;
  logic [XLEN-1:0]   resultReg;

  logic              aNegE;
  logic              bNegE;
  logic              accept;
  logic              stepEn;
  logic              lastStep;
  logic              skipBusy;
  logic [XLEN-1:0]   skipResult;
  logic [XLEN-1:0]   hiNext;
  logic [XLEN-1:0]   loNext;
  logic [2*XLEN-1:0] prodFin;
  logic [XLEN-1:0]   mulResult;
  logic [XLEN-1:0]   finalResult;

  // MULHSU treats only rs1 as signed; MUL needs no sign handling for its low half.
  assign aNegE = SrcAE[XLEN-1] & ((OpE == OP_MULH) | (OpE == OP_MULHSU) | (OpE == OP_DIV) | (OpE == OP_REM));
  assign bNegE = SrcBE[XLEN-1] & ((OpE == OP_MULH) | (OpE == OP_DIV) | (OpE == OP_REM));

  assign accept   = (stateReg == IDLE) & StartE & ~FlushE;
  assign stepEn   = (stateReg == BUSY) & ~FlushE;
  assign lastStep = stepEn & (cntReg == '0);

`ifdef MULDIV_DIV_EN
  logic divZero;
  logic divOvf;
  always_comb begin
    divZero  = (SrcBE == '0);
    divOvf   = ((OpE == OP_DIV) | (OpE == OP_REM)) & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
    skipBusy = OpE[2] & (divZero | divOvf);
    if (divZero) skipResult = OpE[1] ? SrcAE : '1;
    else         skipResult = OpE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end
`else
  assign skipBusy   = OpE[2];
  assign skipResult = '0;
`endif

  md_iter_datapath uDatapath (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .step    (stepEn),
    .isDiv   (opReg[2]),
    .loadA   (negIf(SrcAE, aNegE)),
    .loadB   (negIf(SrcBE, bNegE)),
    .hiNext  (hiNext),
    .loNext  (loNext)
  );

  // The sign fix-up is applied to the last step's combinational output so DONE carries no extra cycle.
  always_comb begin
    prodFin     = (aNegReg ^ bNegReg) ? (~{hiNext, loNext} + 64'd1) : {hiNext, loNext};
    mulResult   = (opReg == OP_MUL) ? prodFin[XLEN-1:0] : prodFin[2*XLEN-1:XLEN];
    finalResult = mulResult;
`ifdef MULDIV_DIV_EN
    if (opReg[2]) finalResult = opReg[1] ? negIf(hiNext, aNegReg) : negIf(loNext, aNegReg ^ bNegReg);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      opReg     <= '0;
      aNegReg   <= 1'b0;
      bNegReg   <= 1'b0;
      resultReg <= '0;
    end else begin
      case (stateReg)
        IDLE: if (accept) begin
          opReg   <= OpE;
          aNegReg <= aNegE;
          bNegReg <= bNegE;
          cntReg  <= ITER_W'(XLEN - 1);
          if (skipBusy) begin
            stateReg  <= DONE;
            resultReg <= skipResult;
          end else begin
            stateReg  <= BUSY;
          end
        end
        BUSY: if (FlushE) begin
          stateReg <= IDLE;
        end else begin
          cntReg <= cntReg - ITER_W'(1);
          if (lastStep) begin
            stateReg  <= DONE;
            resultReg <= finalResult;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign StallMD  = reset_n & (accept | stepEn);
  assign DoneMD   = (stateReg == DONE);
  assign ResultMD = DoneMD ? resultReg : '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush, reset and stall corner sequences.
// Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        StartE;
  logic [2:0]  OpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        StallMD;
  logic        DoneMD;
  logic [31:0] ResultMD;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .StartE   (StartE),
    .OpE      (OpE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .FlushE   (FlushE),
    .StallMD  (StallMD),
    .DoneMD   (DoneMD),
    .ResultMD (ResultMD)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Holds StartE like a stalled EX stage until DoneMD, scrambling operands after accept.
  task automatic runOp(input vec_t v, input string tag);
    int          n;
    int          stalls;
    logic        done;
    logic        stallAtDone;
    logic [31:0] res;
    n = 0; stalls = 0; done = 1'b0; stallAtDone = 1'b0; res = '0;
    @(posedge clk); #1;
    StartE = 1'b1; OpE = v.op; SrcAE = v.a; SrcBE = v.b;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
      if (DoneMD) begin
        done = 1'b1;
        res = ResultMD;
        stallAtDone = StallMD;
      end else begin
        if (StallMD) stalls++;
        @(posedge clk); #1;
        SrcAE = ~v.a;
        SrcBE = v.b ^ 32'h0000_0005;
      end
    end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(v.lat));
    check({tag, " result"}, res, v.res);
    check({tag, " stall cycles"}, 32'(stalls), 32'(v.lat - 1));
    check({tag, " stall in done"}, 32'(stallAtDone), 32'd0);
    @(posedge clk); #1;
    StartE = 1'b0;
    @(negedge clk);
    check({tag, " done after"}, 32'(DoneMD), 32'd0);
    check({tag, " result after"}, ResultMD, 32'd0);
  endtask

  initial begin
    int   doneSeen;
    int   stallSeen;
    vec_t v;

    vecs.push_back('{OP_MUL,    32'd7,        32'd6,        32'd42,       34});
    vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34});
    vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34});
    vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34});
    vecs.push_back('{OP_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34});
    vecs.push_back('{OP_MULHU,  32'h80000000, 32'd4,        32'h00000002, 34});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
    vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{OP_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 2});
    vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2});
    vecs.push_back('{OP_REM,    32'd7,        32'd0,        32'd7,        2});
    vecs.push_back('{OP_REMU,   32'd100,      32'd7,        32'd2,        34});
    vecs.push_back('{OP_REMU,   32'd9,        32'd4,        32'd1,        34});
`else
    vecs.push_back('{OP_REMU,   32'd9,        32'd4,        32'd0,        2});
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'd0,        2});
    vecs.push_back('{OP_DIVU,   32'd100,      32'd0,        32'd0,        2});
`endif
    vecs.push_back('{OP_MUL,    32'd3,        32'd5,        32'd15,       34});

    // Reset held with a live request: every output must stay low.
    reset_n = 1'b0; StartE = 1'b1; FlushE = 1'b0; OpE = OP_MUL; SrcAE = 32'd7; SrcBE = 32'd6;
    #12;
    check("reset stall", 32'(StallMD), 32'd0);
    check("reset done", 32'(DoneMD), 32'd0);
    check("reset result", ResultMD, 32'd0);
    StartE = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) runOp(vecs[i], $sformatf("vec%0d", i));

    // Flushed request in IDLE is never accepted.
    @(posedge clk); #1;
    StartE = 1'b1; FlushE = 1'b1; OpE = OP_MUL; SrcAE = 32'd2; SrcBE = 32'd2;
    stallSeen = 0; doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (StallMD) stallSeen++;
      if (DoneMD) doneSeen++;
    end
    check("idle flush stall", 32'(stallSeen), 32'd0);
    check("idle flush done", 32'(doneSeen), 32'd0);
    @(posedge clk); #1;
    StartE = 1'b0; FlushE = 1'b0;

    // Flush on BUSY cycle 10.
    @(posedge clk); #1;
    StartE = 1'b1; OpE = OP_MUL; SrcAE = 32'd9; SrcBE = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("busy10 stall", 32'(StallMD), 32'd1);
    @(posedge clk); #1;
    FlushE = 1'b1;
    #1;
    check("flush stall drop", 32'(StallMD), 32'd0);
    @(posedge clk); #1;
    FlushE = 1'b0; StartE = 1'b0;
    doneSeen = 0; stallSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (DoneMD) doneSeen++;
      if (StallMD) stallSeen++;
    end
    check("flush no done", 32'(doneSeen), 32'd0);
    check("flush idle stall", 32'(stallSeen), 32'd0);
    v = '{OP_MUL, 32'd11, 32'd13, 32'd143, 34};
    runOp(v, "after flush");

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    StartE = 1'b1; OpE = OP_MULHU; SrcAE = 32'h00010000; SrcBE = 32'h00010000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst stall", 32'(StallMD), 32'd0);
    check("async rst done", 32'(DoneMD), 32'd0);
    check("async rst result", ResultMD, 32'd0);
    StartE = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    v = '{OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 34};
    runOp(v, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
